fp_addsub_seq: RTL and testbench

- Multi-cycle sequencer for the single-precision add/sub datapath: unpack/special-case, align, add, normalize, round, error_check.
- Accepts one operation at a time over a valid/ready request port and drives one-hot stage enables.
- Short-circuits special operands, captures the packed result and error code, and returns them over a valid/ready response port.
- Keeps RISC-V-style sticky exception flags.

---
 rtl/addpkg.sv | 62 ++++++
 rtl/fp_flag_reg.sv | 38 +++
 rtl/fp_addsub_seq.sv | 141 ++++++++++++++
 tb/tb_fp_addsub_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addpkg.sv
// Shared types and constants for the single-precision add/sub datapath and its sequencer.
package addpkg;

    typedef enum logic [2:0] {
        NO_ERR,
        ZERO_OP_ERR,
        INF_ERR,
        NAN_ERR,
        ZERO_ERR
    } i_err_t;

    typedef enum logic [2:0] {
        NONE,
        INVALID,
        DIVZERO,
        OVERFLOW,
        UNDERFLOW,
        INEXACT
    } o_err_t;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        CHECK,
        DONE
    } fp_seq_state_t;

    localparam int unsigned NV_BIT = 4;
    localparam int unsigned DZ_BIT = 3;
    localparam int unsigned OF_BIT = 2;
    localparam int unsigned UF_BIT = 1;
    localparam int unsigned NX_BIT = 0;

    localparam logic [31:0] CANON_NAN = 32'h7FFFFFFF;

    // One-hot stage enables, bit order {round,norm,add,align,unpack}.
    localparam logic [4:0] STG_NONE   = 5'b00000;
    localparam logic [4:0] STG_UNPACK = 5'b00001;
    localparam logic [4:0] STG_ALIGN  = 5'b00010;
    localparam logic [4:0] STG_ADD    = 5'b00100;
    localparam logic [4:0] STG_NORM   = 5'b01000;
    localparam logic [4:0] STG_ROUND  = 5'b10000;

    function automatic logic [4:0] err_to_mask(input o_err_t code);
        logic [4:0] mask;
        mask = '0;
        case (code)
            INVALID:   mask[NV_BIT] = 1'b1;
            DIVZERO:   mask[DZ_BIT] = 1'b1;
            OVERFLOW:  mask[OF_BIT] = 1'b1;
            UNDERFLOW: mask[UF_BIT] = 1'b1;
            INEXACT:   mask[NX_BIT] = 1'b1;
            default:   mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/fp_flag_reg.sv
// Sticky exception flags and normalizer-timeout bit; a clear and a set in the
// same cycle leave the newly set bit standing.
module fp_flag_reg
    import addpkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       set_en,
    input  o_err_t     code,
    input  logic       timeout_set,
    output logic [4:0] flags,
    output logic       timeout
);

    logic [4:0] flags_nxt;
    logic       timeout_nxt;

    always_comb begin
        flags_nxt   = clr ? '0 : flags;
        timeout_nxt = clr ? 1'b0 : timeout;
        if (set_en) begin
            flags_nxt   = flags_nxt | err_to_mask(code);
            timeout_nxt = timeout_nxt | timeout_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags   <= '0;
            timeout <= 1'b0;
        end else begin
            flags   <= flags_nxt;
            timeout <= timeout_nxt;
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle sequencer for the add/sub datapath: walks the stages one at a time,
// short-circuits special operands and bounds the normalizer with a timeout.
module fp_addsub_seq
    import addpkg::*;
#(
    parameter int unsigned NORM_TIMEOUT = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        sub_i,
    output logic [31:0] dp_op_a_o,
    output logic [31:0] dp_op_b_o,
    output logic        dp_sub_o,
    output logic [4:0]  stage_en_o,
    input  i_err_t      err_i,
    input  logic        norm_done_i,
    input  logic [31:0] fp_i,
    input  o_err_t      err_code_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_o,
    output o_err_t      res_err_o,
    input  logic        flags_clr_i,
    output logic [4:0]  flags_o,
    output logic        timeout_o
);

    localparam int unsigned CNT_W = (NORM_TIMEOUT > 1) ? $clog2(NORM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NORM_TIMEOUT - 1);

    fp_seq_state_t    state;
    logic [CNT_W-1:0] norm_cnt;
    logic             abort;
    logic             check_stage;
    o_err_t           check_code;

    always_comb begin
        check_stage = (state == CHECK);
        check_code  = abort ? INVALID : err_code_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            res_valid_o <= 1'b0;
            stage_en_o  <= STG_NONE;
            res_o       <= '0;
            res_err_o   <= NONE;
            dp_op_a_o   <= '0;
            dp_op_b_o   <= '0;
            dp_sub_o    <= 1'b0;
            norm_cnt    <= '0;
            abort       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        dp_op_a_o   <= op_a_i;
                        dp_op_b_o   <= op_b_i;
                        dp_sub_o    <= sub_i;
                        abort       <= 1'b0;
                        req_ready_o <= 1'b0;
                        stage_en_o  <= STG_UNPACK;
                        state       <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (err_i == NO_ERR) begin
                        stage_en_o <= STG_ALIGN;
                        state      <= ALIGN;
                    end else begin
                        stage_en_o <= STG_NONE;
                        state      <= CHECK;
                    end
                end
                ALIGN: begin
                    stage_en_o <= STG_ADD;
                    state      <= ADD;
                end
                ADD: begin
                    norm_cnt   <= '0;
                    stage_en_o <= STG_NORM;
                    state      <= NORM;
                end
                NORM: begin
                    // Done is tested before the limit so a finish on the last counted cycle is not aborted.
                    if (norm_done_i) begin
                        stage_en_o <= STG_ROUND;
                        state      <= ROUND;
                    end else if (norm_cnt == CNT_LAST) begin
                        abort      <= 1'b1;
                        stage_en_o <= STG_NONE;
                        state      <= CHECK;
                    end else begin
                        norm_cnt <= norm_cnt + 1'b1;
                    end
                end
                ROUND: begin
                    stage_en_o <= STG_NONE;
                    state      <= CHECK;
                end
                CHECK: begin
                    res_o       <= abort ? CANON_NAN : fp_i;
                    res_err_o   <= check_code;
                    res_valid_o <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    stage_en_o  <= STG_NONE;
                    res_valid_o <= 1'b0;
                    req_ready_o <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    fp_flag_reg u_flags (
        .clk         (clk),
        .rst         (rst),
        .clr         (flags_clr_i),
        .set_en      (check_stage),
        .code        (check_code),
        .timeout_set (abort),
        .flags       (flags_o),
        .timeout     (timeout_o)
    );

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq: directed vector table, random operations
// against a latency/flag model, stall/back-to-back and reset-in-flight sequences.
module tb_fp_addsub_seq;
    import addpkg::*;

    localparam int TO = 27;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] op_a_i, op_b_i;
    logic        sub_i;
    logic [31:0] dp_op_a_o, dp_op_b_o;
    logic        dp_sub_o;
    logic [4:0]  stage_en_o;
    i_err_t      err_i;
    logic        norm_done_i;
    logic [31:0] cur_fp;
    o_err_t      cur_code;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [31:0] res_o;
    o_err_t      res_err_o;
    logic        flags_clr_i;
    logic [4:0]  flags_o;
    logic        timeout_o;

    i_err_t      cur_cls;
    int          cur_delay;
    bit          cur_chk_clr;
    bit          clr_pulse;
    logic [3:0]  junk;
    int          norm_cnt;

    int total = 0;
    int bad = 0;
    logic [4:0] m_flags;
    bit         m_to;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          sub;
        i_err_t      cls;
        int          delay;
        logic [31:0] fp;
        o_err_t      code;
        bit          pre_clr;
        bit          chk_clr;
        int          exp_lat;
        int          exp_norm;
        logic [31:0] exp_res;
        o_err_t      exp_err;
        logic [4:0]  exp_flags;
        bit          exp_to;
    } vec_t;

    fp_addsub_seq #(.NORM_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .op_a_i      (op_a_i),
        .op_b_i      (op_b_i),
        .sub_i       (sub_i),
        .dp_op_a_o   (dp_op_a_o),
        .dp_op_b_o   (dp_op_b_o),
        .dp_sub_o    (dp_sub_o),
        .stage_en_o  (stage_en_o),
        .err_i       (err_i),
        .norm_done_i (norm_done_i),
        .fp_i        (cur_fp),
        .err_code_i  (cur_code),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_o       (res_o),
        .res_err_o   (res_err_o),
        .flags_clr_i (flags_clr_i),
        .flags_o     (flags_o),
        .timeout_o   (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: junk on inputs outside the stage that consumes them.
    initial forever begin
        @(negedge clk);
        junk = 4'($urandom);
    end
    always @(posedge clk) norm_cnt <= stage_en_o[3] ? norm_cnt + 1 : 0;
    assign err_i = stage_en_o[0] ? cur_cls : i_err_t'(junk[2:0]);
    assign norm_done_i = stage_en_o[3] ? (norm_cnt == cur_delay) : junk[3];
    assign flags_clr_i = clr_pulse | (cur_chk_clr & (stage_en_o == 5'd0) & ~req_ready_o & ~res_valid_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] flag_of(input o_err_t e);
        case (e)
            INVALID:   return 5'b10000;
            DIVZERO:   return 5'b01000;
            OVERFLOW:  return 5'b00100;
            UNDERFLOW: return 5'b00010;
            INEXACT:   return 5'b00001;
            default:   return 5'b00000;
        endcase
    endfunction

    // Expected outcome from the operation's class, normalizer delay and sticky history.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit special, abrt;
        r = v;
        special = (v.cls != NO_ERR);
        abrt = !special && (v.delay >= TO);
        r.exp_lat  = special ? 3 : (abrt ? 5 + TO : 7 + v.delay);
        r.exp_norm = special ? 0 : (abrt ? TO : v.delay + 1);
        r.exp_res  = abrt ? 32'h7FFFFFFF : v.fp;
        r.exp_err  = abrt ? INVALID : v.code;
        r.exp_flags = ((v.pre_clr || v.chk_clr) ? 5'b0 : m_flags) | flag_of(r.exp_err);
        r.exp_to    = ((v.pre_clr || v.chk_clr) ? 1'b0 : m_to) | abrt;
        return r;
    endfunction

    task automatic run_op(input vec_t v, input int stall, input bit hold, input vec_t nxt);
        int lat, normc;
        bit arith, multi;
        cur_cls = v.cls; cur_delay = v.delay; cur_fp = v.fp; cur_code = v.code;
        cur_chk_clr = v.chk_clr;
        if (v.pre_clr) begin
            @(negedge clk); clr_pulse = 1'b1;
            @(negedge clk); clr_pulse = 1'b0;
        end
        @(negedge clk);
        req_valid_i = 1'b1; op_a_i = v.a; op_b_i = v.b; sub_i = v.sub;
        @(posedge clk); #1;
        req_valid_i = 1'b0; op_a_i = $urandom; op_b_i = $urandom; sub_i = ~v.sub;
        lat = 0; normc = 0; arith = 0; multi = 0;
        for (int c = 1; c <= 200; c++) begin
            if (res_valid_o) begin
                lat = c;
                break;
            end
            if (stage_en_o[3]) normc++;
            if (|stage_en_o[4:1]) arith = 1;
            if ($countones(stage_en_o) > 1) multi = 1;
            @(posedge clk); #1;
        end
        chk("latency", lat, v.exp_lat);
        chk("norm_cycles", normc, v.exp_norm);
        chk("arith_stages", arith, v.cls == NO_ERR);
        chk("stage_onehot", multi, 0);
        chk("res", res_o, v.exp_res);
        chk("res_err", res_err_o, v.exp_err);
        chk("flags", flags_o, v.exp_flags);
        chk("timeout", timeout_o, v.exp_to);
        chk("dp_a", dp_op_a_o, v.a);
        chk("dp_b", dp_op_b_o, v.b);
        chk("dp_sub", dp_sub_o, v.sub);
        chk("ready_in_done", req_ready_o, 0);
        if (hold) begin
            req_valid_i = 1'b1; op_a_i = nxt.a; op_b_i = nxt.b; sub_i = nxt.sub;
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_valid", res_valid_o, 1);
            chk("stall_res", res_o, v.exp_res);
            chk("stall_err", res_err_o, v.exp_err);
            chk("stall_ready", req_ready_o, 0);
        end
        res_ready_i = 1'b1;
        @(posedge clk); #1;
        res_ready_i = 1'b0;
        chk("valid_drop", res_valid_o, 0);
        chk("ready_back", req_ready_o, 1);
        if (hold) chk("no_same_cycle_accept", stage_en_o, 0);
        m_flags = v.exp_flags;
        m_to = v.exp_to;
    endtask

    vec_t tbl[11];
    vec_t v, v2;
    int r;
    bit got, seen;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid_i = 1'b0; op_a_i = '0; op_b_i = '0; sub_i = 1'b0;
        res_ready_i = 1'b0; clr_pulse = 1'b0; cur_chk_clr = 1'b0;
        cur_cls = NO_ERR; cur_delay = 0; cur_fp = '0; cur_code = NONE;
        m_flags = '0; m_to = 1'b0;

        //        a             b             sub   cls          dly  fp            code       pre   chk   lat norm res           err       flags     to
        tbl[0]  = '{32'h3F800000, 32'h40000000, 1'b0, NO_ERR,      0,   32'h40400000, NONE,      1'b1, 1'b0, 7,  1,  32'h40400000, NONE,     5'b00000, 1'b0};
        tbl[1]  = '{32'h7FC00000, 32'h3F800000, 1'b0, NAN_ERR,     0,   32'h7FFFFFFF, INVALID,   1'b1, 1'b0, 3,  0,  32'h7FFFFFFF, INVALID,  5'b10000, 1'b0};
        tbl[2]  = '{32'h3F800000, 32'h3F800000, 1'b1, NO_ERR,      100, 32'h12345678, NONE,      1'b1, 1'b0, 32, 27, 32'h7FFFFFFF, INVALID,  5'b10000, 1'b1};
        tbl[3]  = '{32'h40000000, 32'h40400000, 1'b0, NO_ERR,      26,  32'h40A00000, INEXACT,   1'b1, 1'b0, 33, 27, 32'h40A00000, INEXACT,  5'b00001, 1'b0};
        tbl[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, NO_ERR,      2,   32'h7F800000, OVERFLOW,  1'b0, 1'b1, 9,  3,  32'h7F800000, OVERFLOW, 5'b00100, 1'b0};
        tbl[5]  = '{32'h7F800000, 32'h3F800000, 1'b0, INF_ERR,     0,   32'h7F800000, NONE,      1'b1, 1'b0, 3,  0,  32'h7F800000, NONE,     5'b00000, 1'b0};
        tbl[6]  = '{32'h00000000, 32'h3F800000, 1'b0, ZERO_OP_ERR, 0,   32'h3F800000, NONE,      1'b1, 1'b0, 3,  0,  32'h3F800000, NONE,     5'b00000, 1'b0};
        tbl[7]  = '{32'h3F800000, 32'h3F800000, 1'b1, ZERO_ERR,    0,   32'h00000000, NONE,      1'b1, 1'b0, 3,  0,  32'h00000000, NONE,     5'b00000, 1'b0};
        tbl[8]  = '{32'h00800000, 32'h00000001, 1'b1, NO_ERR,      3,   32'h00400000, UNDERFLOW, 1'b1, 1'b0, 10, 4,  32'h00400000, UNDERFLOW,5'b00010, 1'b0};
        tbl[9]  = '{32'h3F800000, 32'h00000000, 1'b0, NO_ERR,      0,   32'h3F800000, DIVZERO,   1'b1, 1'b0, 7,  1,  32'h3F800000, DIVZERO,  5'b01000, 1'b0};
        tbl[10] = '{32'h3F000000, 32'h3F000000, 1'b0, NO_ERR,      25,  32'h3F800000, NONE,      1'b1, 1'b0, 32, 26, 32'h3F800000, NONE,     5'b00000, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_res_valid", res_valid_o, 0);
        chk("rst_stage_en", stage_en_o, 0);
        chk("rst_res", res_o, 0);
        chk("rst_res_err", res_err_o, NONE);
        chk("rst_flags", flags_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_dp_a", dp_op_a_o, 0);
        chk("rst_dp_b", dp_op_b_o, 0);
        chk("rst_dp_sub", dp_sub_o, 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_op(tbl[i], i % 3, 1'b0, tbl[i]);

        for (int n = 0; n < 40; n++) begin
            v.a = $urandom; v.b = $urandom; v.sub = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            v.cls = (r < 6) ? NO_ERR : i_err_t'(3'(r - 5));
            r = $urandom_range(0, 9);
            v.delay = (r < 8) ? $urandom_range(0, 6) : $urandom_range(25, 29);
            v.fp = $urandom;
            v.code = o_err_t'(3'($urandom_range(0, 5)));
            v.pre_clr = 1'b0;
            v.chk_clr = ($urandom_range(0, 5) == 0);
            v = model(v);
            run_op(v, $urandom_range(0, 3), 1'b0, v);
        end

        // Long stall in DONE with the next request already waiting.
        v = '{32'h40000000, 32'h3F800000, 1'b1, NO_ERR, 1, 32'h3F800000, INEXACT,
              1'b0, 1'b0, 0, 0, 32'h0, NONE, 5'b0, 1'b0};
        v = model(v);
        v2 = '{32'h41200000, 32'h40A00000, 1'b0, NO_ERR, 0, 32'h41700000, NONE,
               1'b0, 1'b0, 0, 0, 32'h0, NONE, 5'b0, 1'b0};
        run_op(v, 10, 1'b1, v2);
        v2 = model(v2);
        run_op(v2, 0, 1'b0, v2);

        v = '{32'h3F800000, 32'h3F800000, 1'b0, NO_ERR, 0, 32'h40000000, INEXACT,
              1'b0, 1'b0, 0, 0, 32'h0, NONE, 5'b0, 1'b0};
        v = model(v);
        run_op(v, 0, 1'b0, v);

        // Reset while the normalizer is running.
        cur_cls = NO_ERR; cur_delay = 1000; cur_chk_clr = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b1; op_a_i = 32'h3F800000; op_b_i = 32'h40000000; sub_i = 1'b0;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            if (stage_en_o[3]) got = 1;
        end
        chk("reached_norm", got, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_ready", req_ready_o, 1);
        chk("mid_rst_valid", res_valid_o, 0);
        chk("mid_rst_stage", stage_en_o, 0);
        chk("mid_rst_flags", flags_o, 0);
        chk("mid_rst_timeout", timeout_o, 0);
        seen = 0;
        res_ready_i = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (res_valid_o) seen = 1;
        end
        res_ready_i = 1'b0;
        chk("no_resp_after_rst", seen, 0);
        chk("idle_after_rst", req_ready_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
